code_loader: RTL
================

# code_loader

Byte-stream program loader that writes the instruction memory read by the fetch stage. It accepts a length-prefixed little-endian byte stream from a host link (UART/JTAG bridge), assembles 32-bit instruction words and issues one aligned write per word into the code memory's write port. It sits between the host link and the code memory and holds `busy_o` high so the core stays parked until the image is complete.

## Interface
- `ADDR_WIDTH`, 64, width of the byte address driven on `waddr_o`
- `ROM_SIZE`, 16, byte-address bits decoded by the code memory; capacity is 2**(ROM_SIZE-2) words
- `BASE_ADDR`, 0, byte address of word 0; must be 4-byte aligned
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `start_i`  in  1  single-cycle pulse that arms the loader; honoured only in IDLE, DONE or ERR
- `byte_valid_i`  in  1  host byte valid
- `byte_data_i`  in  8  host byte
- `byte_ready_o`  out  1  loader can accept a byte this cycle
- `we_o`  out  1  code-memory write strobe, one cycle per word
- `waddr_o`  out  ADDR_WIDTH  byte address of the write, always 4-byte aligned
- `wdata_o`  out  32  instruction word
- `busy_o`  out  1  load in progress (HDR, DATA, WRITE, CSUM)
- `done_o`  out  1  image loaded successfully; sticky
- `error_o`  out  1  load aborted; sticky
- `err_code_o`  out  2  0 none, 1 length exceeds capacity, 2 checksum mismatch
- `words_o`  out  ROM_SIZE-1  number of words written in the current or last load

## Operation
- States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- A byte is transferred when `byte_valid_i && byte_ready_o`. `byte_ready_o` is 1 only in HDR, DATA and CSUM.
- IDLE/DONE/ERR + `start_i` -> HDR. Clears the byte index, the word counter, `done_o`, `error_o` and `err_code_o`. `start_i` in any other state is ignored.
- HDR: collects 4 bytes little-endian into LEN, the word count.
  - If LEN > 2**(ROM_SIZE-2): go to ERR with code 1.
  - If LEN == 0: go to CSUM when checksum is enabled, else DONE.
  - Otherwise go to DATA.
- DATA: shifts in 4 bytes, first byte into [7:0]. After the 4th byte is accepted, go to WRITE.
- WRITE: lasts exactly one cycle.
  - `we_o`=1, `wdata_o`=assembled word, `waddr_o`=BASE_ADDR + 4*`words_o`.
  - `words_o` increments at the end of the cycle.
  - If `words_o`+1 == LEN: go to CSUM or DONE. Otherwise return to DATA.
- Byte order within a word and across bytes is strict. There is no timeout; a stalled host leaves the loader waiting indefinitely.
- Address arithmetic is modulo 2**ADDR_WIDTH. `words_o` never exceeds capacity because of the HDR check.

## Timing
- Reset values:
  - state IDLE
  - `byte_ready_o`, `we_o`, `busy_o`, `done_o`, `error_o` = 0
  - `waddr_o`, `wdata_o`, `err_code_o`, `words_o` = 0
- Reset does not touch memory contents. Reset mid-load abandons the load, and partially written words remain in memory.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum 5 cycles per word: 4 byte-accept cycles plus 1 WRITE cycle with `byte_ready_o`=0.
- `we_o` asserts the cycle after the 4th byte of a word is accepted.
- `done_o`/`error_o` rise the cycle after the final accepted byte or the final WRITE, and hold until `start_i` or reset.
- `wdata_o`/`waddr_o` hold their last value outside WRITE.

## Configuration
- `CODE_LOADER_CHECKSUM_EN` defined:
  - After the last word, CSUM accepts 4 bytes little-endian.
  - They are compared with the sum modulo 2**32 of all written words; a zero-length image expects 0.
  - Match -> DONE. Mismatch -> ERR with code 2.
  - Words are already written regardless of the outcome.
- Undefined: the CSUM state and the sum adder are absent. The load ends in DONE directly after the last WRITE or after a zero LEN, and code 2 never occurs.

## Test plan
- Load of 2 words, bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4. `words_o`=2, `done_o`=1, `error_o`=0.
- Same stream with `byte_valid_i` randomly deasserted and BASE_ADDR=0x100 -> identical data at 0x100/0x104. `we_o` pulses exactly twice, each 1 cycle. `byte_ready_o`=0 during each WRITE.
- LEN=0x4001 with ROM_SIZE=16 -> ERR, `err_code_o`=1, no `we_o` pulses, `byte_ready_o`=0 afterwards. A new `start_i` rearms the loader.
- `rst_ni` pulsed low after 6 bytes of a 2-word load -> all outputs return to 0 asynchronously and state is IDLE. A fresh `start_i` and full stream then complete normally.
- With CHECKSUM_EN, 1 word 0x00000013 followed by checksum 13 00 00 00 -> DONE. With checksum 14 00 00 00 -> ERR, code 2, and the word is still written once.
- `start_i` pulsed mid-DATA -> ignored; the load completes normally with unchanged `words_o` sequencing.

Source files
------------

// File: rtl/code_loader.sv
// code_loader: length-prefixed little-endian byte stream to 32-bit code-memory writes.
// Optional trailing word checksum: define CODE_LOADER_CHECKSUM_EN. Rev 1.0
`default_nettype none

module code_loader #(
  parameter int unsigned            ADDR_WIDTH = 64,
  parameter int unsigned            ROM_SIZE   = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [31:0]           wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [1:0]            err_code_o,
  output logic [ROM_SIZE-2:0]   words_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [32:0] CAPACITY = 33'd1 << (ROM_SIZE - 2);
`ifdef CODE_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic [2:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [31:0]           len_q, len_d;
  logic [ROM_SIZE-2:0]   words_q, words_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_q, err_d;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  logic        ready;
  logic        fire;
  logic        last_byte;
  logic [31:0] word_in;

  assign ready     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign fire      = byte_valid_i && ready;
  assign last_byte = fire && (idx_q == 2'd3);
  // First byte of each group ends up in [7:0] after four shifts.
  assign word_in   = {byte_data_i, shreg_q[31:8]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    len_d   = len_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;
`ifdef CODE_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (fire) begin
      shreg_d = word_in;
      idx_d   = idx_q + 2'd1;
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          idx_d   = 2'd0;
          words_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = 2'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_HDR: begin
        if (last_byte) begin
          len_d = word_in;
          if ({1'b0, word_in} > CAPACITY) begin
            state_d = S_ERR;
            error_d = 1'b1;
            err_d   = 2'd1;
          end else if (word_in == 32'd0) begin
            state_d = CSUM_EN ? S_CSUM : S_DONE;
            done_d  = !CSUM_EN;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          state_d = S_WRITE;
          wdata_d = word_in;
          waddr_d = BASE_ADDR + (ADDR_WIDTH'(words_q) << 2);
        end
      end
      S_WRITE: begin
        words_d = words_q + 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
        if (32'(words_q) + 32'd1 == len_q) begin
          state_d = CSUM_EN ? S_CSUM : S_DONE;
          done_d  = !CSUM_EN;
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (last_byte) begin
          if (word_in == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            err_d   = 2'd2;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      shreg_q <= '0;
      len_q   <= '0;
      words_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= 2'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      len_q   <= len_d;
      words_q <= words_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Status strobes are pure decodes of the state register.
  assign byte_ready_o = ready;
  assign we_o         = (state_q == S_WRITE);
  assign busy_o       = ready || (state_q == S_WRITE);
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_code_o   = err_q;
  assign words_o      = words_q;

endmodule

`default_nettype wire
